lzc_tree: RTL and testbench

LZC_TREE -- requirements
Module: lzc

---
 rtl/lzc_tree.sv | 92 +++++++++
 tb/tb_lzc_tree.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/lzc_tree.sv
`default_nettype none
// ============================================================================
// Module      : lzc_tree
// Description : Combinational leading/trailing zero counter built as a
//               balanced binary tree of (valid, index) select nodes.
//               MODE=0 counts trailing zeros (index of the lowest set bit).
//               MODE=1 counts leading zeros (zeros above the highest set bit).
// Ports       : clk_i   - clock for the simulation-only checks
//               rst_i   - synchronous active-high reset; disables the checks
//               in_i    - WIDTH-bit vector to scan
//               cnt_o   - zero count, CNT_W bits; 0 when in_i is all zeros
//               empty_o - high when in_i is all zeros
// Revision    : 1.0 - initial release
// ============================================================================
module lzc_tree #(
    parameter int unsigned WIDTH = 2,
    parameter bit          MODE  = 1'b0,
    localparam int unsigned LVLS  = (WIDTH > 1) ? $clog2(WIDTH) : 0,
    localparam int unsigned CNT_W = (LVLS > 0) ? LVLS : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] in_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             empty_o
);

    // Leaf count rounded up to the next power of two.
    localparam int unsigned PW = 1 << LVLS;

    // Scan-order leaves: leaf 0 is the first bit examined. Leading-zero mode
    // reverses the input so the same lowest-first tree can be reused.
    logic [PW-1:0] w_leaf;

    // Heap-ordered tree: node 1 is the root, node n has children 2n and
    // 2n+1, leaves sit at PW..2*PW-1.
    logic [2*PW-1:1]            w_vld;
    logic [2*PW-1:1][CNT_W-1:0] w_idx;

    for (genvar j = 0; j < PW; j++) begin : g_leaf
        if (j >= WIDTH) begin : g_pad
            assign w_leaf[j] = 1'b0;
        end else if (MODE) begin : g_rev
            assign w_leaf[j] = in_i[WIDTH-1-j];
        end else begin : g_fwd
            assign w_leaf[j] = in_i[j];
        end
        assign w_vld[PW+j] = w_leaf[j];
        assign w_idx[PW+j] = CNT_W'(j);
    end

    // Each node prefers its lower (left) child, which covers the earlier
    // leaves in scan order, so the root reports the first set leaf.
    for (genvar lv = 0; lv < LVLS; lv++) begin : g_lvl
        for (genvar k = 0; k < (1 << lv); k++) begin : g_node
            localparam int unsigned N = (1 << lv) + k;
            assign w_vld[N] = w_vld[2*N] | w_vld[2*N+1];
            assign w_idx[N] = w_vld[2*N] ? w_idx[2*N] : w_idx[2*N+1];
        end
    end

    // With no set bit the root index would point at the last (possibly
    // padded) leaf, so force it to zero.
    assign cnt_o   = w_vld[1] ? w_idx[1] : '0;
    assign empty_o = ~|in_i;

`ifndef SYNTHESIS
    if (WIDTH == 0) begin : g_bad_width
        $fatal(1, "lzc_tree: WIDTH must be at least 1");
    end

    // Move the reported bit to a fixed position so no variable bit-select
    // is needed: bit 0 for trailing mode, bit WIDTH-1 for leading mode.
    logic [WIDTH-1:0] w_chk;
    logic             w_chk_bit;
    assign w_chk     = MODE ? (in_i << cnt_o) : (in_i >> cnt_o);
    assign w_chk_bit = MODE ? w_chk[WIDTH-1] : w_chk[0];

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!$isunknown(in_i))
                else $error("lzc_tree: in_i contains X/Z");
            if (!empty_o) begin
                assert (w_chk_bit)
                    else $error("lzc_tree: cnt_o does not point at a set bit");
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lzc_tree.sv
`default_nettype none
// ============================================================================
// Module      : tb_lzc_tree
// Description : Self-checking bench for lzc_tree. Ten instances cover
//               WIDTH in {1,2,5,8,13} for both modes, all fed from slices of
//               one 13-bit stimulus word and compared with a bit-scan model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lzc_tree;

    localparam int NINST = 10;
    localparam int WS [5] = '{1, 2, 5, 8, 13};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] tb_in = '0;

    logic [3:0] cnt_a [NINST];
    logic       emp_a [NINST];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    // Instance k: width WS[k/2], mode k%2.
    for (genvar k = 0; k < NINST; k++) begin : g_dut
        localparam int unsigned W  = WS[k/2];
        localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
        logic [CW-1:0] c;
        logic          e;
        lzc_tree #(
            .WIDTH (W),
            .MODE  (1'(k % 2))
        ) u_dut (
            .clk_i   (clk),
            .rst_i   (rst),
            .in_i    (tb_in[W-1:0]),
            .cnt_o   (c),
            .empty_o (e)
        );
        assign cnt_a[k] = 4'(c);
        assign emp_a[k] = e;
    end

    // Walk bits in scan order; the count is the scan position of the first
    // set bit, or 0 if there is none.
    function automatic int ref_cnt(input logic [12:0] v, input int w, input int mode);
        for (int i = 0; i < w; i++) begin
            int p;
            p = (mode != 0) ? (w - 1 - i) : i;
            if (v[p]) return i;
        end
        return 0;
    endfunction

    function automatic bit ref_empty(input logic [12:0] v, input int w);
        for (int i = 0; i < w; i++) begin
            if (v[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        tb_in = '0;
        #2;
        for (int k = 0; k < NINST; k++) begin
            compared++;
            if (cnt_a[k] !== 4'd0 || emp_a[k] !== 1'b1) begin
                mismatched++;
                $display("FAIL reset_zero inst=%0d got cnt=%0d empty=%0b want cnt=0 empty=1",
                         k, cnt_a[k], emp_a[k]);
            end
        end
        // Outputs must follow the input while reset is still asserted.
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            tb_in = 13'($urandom);
            #2;
            for (int k = 0; k < NINST; k++) begin
                int  w;
                int  m;
                int  ec;
                bit  ee;
                w  = WS[k/2];
                m  = k % 2;
                ec = ref_cnt(tb_in, w, m);
                ee = ref_empty(tb_in, w);
                compared++;
                if (cnt_a[k] !== 4'(ec) || emp_a[k] !== ee) begin
                    mismatched++;
                    $display("FAIL reset_track inst=%0d in=%h got cnt=%0d empty=%0b want cnt=%0d empty=%0b",
                             k, tb_in, cnt_a[k], emp_a[k], ec, ee);
                end
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [12:0] vin  [6];
        int          inst [6];
        int          ecnt [6];
        bit          eemp [6];
        vin[0] = 13'b0_0000_0000_0000; inst[0] = 8; ecnt[0] = 0;  eemp[0] = 1'b1;
        vin[1] = 13'b1_0000_0010_1000; inst[1] = 8; ecnt[1] = 3;  eemp[1] = 1'b0;
        vin[2] = 13'b1_0000_0000_0000; inst[2] = 8; ecnt[2] = 12; eemp[2] = 1'b0;
        vin[3] = 13'h1FFF;             inst[3] = 8; ecnt[3] = 0;  eemp[3] = 1'b0;
        vin[4] = 13'b0_0100_0000_0001; inst[4] = 9; ecnt[4] = 2;  eemp[4] = 1'b0;
        vin[5] = 13'b0_0000_0000_0001; inst[5] = 9; ecnt[5] = 12; eemp[5] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tb_in = vin[i];
            #2;
            compared++;
            if (cnt_a[inst[i]] !== 4'(ecnt[i]) || emp_a[inst[i]] !== eemp[i]) begin
                mismatched++;
                $display("FAIL directed_%0d in=%b got cnt=%0d empty=%0b want cnt=%0d empty=%0b",
                         i, vin[i], cnt_a[inst[i]], emp_a[inst[i]], ecnt[i], eemp[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            // Sparse words exercise deep first-set positions more often.
            tb_in = (n % 2 == 0) ? 13'($urandom) : 13'($urandom & $urandom & $urandom);
            #2;
            for (int k = 0; k < NINST; k++) begin
                int  w;
                int  ec;
                bit  ee;
                w  = WS[k/2];
                ec = ref_cnt(tb_in, w, k % 2);
                ee = ref_empty(tb_in, w);
                compared++;
                if (cnt_a[k] !== 4'(ec) || emp_a[k] !== ee) begin
                    mismatched++;
                    $display("FAIL random inst=%0d in=%h got cnt=%0d empty=%0b want cnt=%0d empty=%0b",
                             k, tb_in, cnt_a[k], emp_a[k], ec, ee);
                end
            end
        end
    endtask

    // Every 13-bit word covers every value of every narrower slice; reset is
    // pulsed through the middle of the sweep.
    task automatic test_sweep();
        for (int v = 0; v < 8192; v++) begin
            @(negedge clk);
            tb_in = 13'(v);
            rst   = (v >= 3000 && v < 3400);
            #2;
            for (int k = 0; k < NINST; k++) begin
                int  w;
                int  ec;
                bit  ee;
                w  = WS[k/2];
                ec = ref_cnt(tb_in, w, k % 2);
                ee = ref_empty(tb_in, w);
                compared++;
                if (cnt_a[k] !== 4'(ec) || emp_a[k] !== ee) begin
                    mismatched++;
                    $display("FAIL sweep inst=%0d in=%h rst=%0b got cnt=%0d empty=%0b want cnt=%0d empty=%0b",
                             k, tb_in, rst, cnt_a[k], emp_a[k], ec, ee);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_sweep();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
